// File: rtl/adc_ltc1407a_responder.sv
// LTC1407A-1 device-side responder: oversamples SPI_SCK/AD_CONV and shifts a 34-bit sample frame out on ADC_OUT.
// Optional macro ADC_RESP_TEST_PATTERN_EN replaces the sample ports with an internal counter pattern.
module adc_ltc1407a_responder #(
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned DUMMY_BITS  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic              SPI_SCK,
  input  logic              AD_CONV,
  output logic              ADC_OUT,
  input  logic [DATA_W-1:0] CH0_DATA,
  input  logic [DATA_W-1:0] CH1_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              OVERRUN
);

  localparam int unsigned FW = 2 * DATA_W + 3 * DUMMY_BITS;
  localparam int unsigned CW = $clog2(FW);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sck_sync, conv_sync;
  logic                   sck_hist, conv_hist;
  logic                   sck_fall, conv_rise;
  logic [CW-1:0]          cnt, cnt_d;
  logic [FW-2:0]          shreg, shreg_d;
  logic                   adc_d, done_d, ovr_d;
  logic [DATA_W-1:0]      ch0_src, ch1_src;
  logic [FW-1:0]          frame_in;

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      sck_sync  <= '0;
      conv_sync <= '0;
      sck_hist  <= 1'b0;
      conv_hist <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      conv_sync <= {conv_sync[SYNC_STAGES-2:0], AD_CONV};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      conv_hist <= conv_sync[SYNC_STAGES-1];
    end
  end

  assign sck_fall  = sck_hist & ~sck_sync[SYNC_STAGES-1];
  assign conv_rise = conv_sync[SYNC_STAGES-1] & ~conv_hist;

`ifdef ADC_RESP_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat;

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      pat <= '0;
    end else if (conv_rise) begin
      pat <= pat + DATA_W'(1);
    end
  end

  assign ch0_src = pat;
  assign ch1_src = ~pat;
`else
  assign ch0_src = CH0_DATA;
  assign ch1_src = CH1_DATA;
`endif

  assign frame_in = {{DUMMY_BITS{1'b0}}, ch0_src, {DUMMY_BITS{1'b0}}, ch1_src, {DUMMY_BITS{1'b0}}};

  // The MSB is driven straight onto ADC_OUT at latch time, so the shift register only holds the remaining bits.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    adc_d   = ADC_OUT;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    if (conv_rise) begin
      ovr_d   = (state == SHIFT);
      shreg_d = frame_in[FW-2:0];
      adc_d   = frame_in[FW-1];
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state == SHIFT && sck_fall) begin
      if (cnt == CW'(FW - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        adc_d   = 1'b0;
        done_d  = 1'b1;
      end else begin
        cnt_d   = cnt + CW'(1);
        adc_d   = shreg[FW-2];
        shreg_d = {shreg[FW-3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      ADC_OUT    <= 1'b0;
      FRAME_DONE <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      shreg      <= shreg_d;
      ADC_OUT    <= adc_d;
      FRAME_DONE <= done_d;
      OVERRUN    <= ovr_d;
    end
  end

  assign BUSY = (state == SHIFT);

endmodule

// File: tb/tb_adc_ltc1407a_responder.sv
// Directed bench for adc_ltc1407a_responder: pin-level frame model checked every cycle plus literal frame checks.
module tb_adc_ltc1407a_responder;

  localparam int DATA_W = 14;
  localparam int FW     = 34;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck = 1'b0;
  logic              conv = 1'b0;
  logic              adc_out;
  logic [DATA_W-1:0] ch0 = '0;
  logic [DATA_W-1:0] ch1 = '0;
  logic              busy, frame_done, overrun;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  int ovr_seen = 0;
  logic [FW-1:0] got;

  adc_ltc1407a_responder #(.DATA_W(14), .DUMMY_BITS(2), .SYNC_STAGES(2)) dut (
    .CLK50MHZ(clk), .RST(rst_n), .SPI_SCK(sck), .AD_CONV(conv), .ADC_OUT(adc_out),
    .CH0_DATA(ch0), .CH1_DATA(ch1), .BUSY(busy), .FRAME_DONE(frame_done), .OVERRUN(overrun)
  );

  always #10 clk = ~clk;

  // Model: pin history delayed by the synchronizer latency, frame held as a vector indexed by fall count.
  logic [LAT:0]  sck_h, conv_h;
  logic          m_active, m_done, m_ovr;
  int            m_k;
  logic [FW-1:0] m_frame;
  logic [DATA_W-1:0] m_pat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_h = '0; conv_h = '0; m_active = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
      m_k = 0; m_frame = '0; m_pat = '0;
    end else begin
      sck_h  = {sck_h[LAT-1:0], sck};
      conv_h = {conv_h[LAT-1:0], conv};
      m_done = 1'b0;
      m_ovr  = 1'b0;
      if (conv_h[LAT-1] && !conv_h[LAT]) begin
        m_ovr = m_active;
`ifdef ADC_RESP_TEST_PATTERN_EN
        m_frame = {2'b00, m_pat, 2'b00, ~m_pat, 2'b00};
        m_pat   = m_pat + 1;
`else
        m_frame = {2'b00, ch0, 2'b00, ch1, 2'b00};
`endif
        m_active = 1'b1;
        m_k = 0;
      end else if (m_active && sck_h[LAT] && !sck_h[LAT-1]) begin
        m_k = m_k + 1;
        if (m_k == FW) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("adc_out", 64'(adc_out), 64'(m_active ? m_frame[FW-1-m_k] : 1'b0));
      chk("busy", 64'(busy), 64'(m_active));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      if (frame_done) done_seen++;
      if (overrun) ovr_seen++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic conv_pulse();
    conv = 1'b1;
    wait_clk(4);
    conv = 1'b0;
    wait_clk(6);
  endtask

  // Master samples ADC_OUT as it raises SCK, then drops SCK to request the next bit.
  task automatic sck_bits(input int n);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[FW-2:0], adc_out};
      sck = 1'b1;
      wait_clk(10);
      sck = 1'b0;
      wait_clk(10);
    end
  endtask

  task automatic frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    ch0 = a;
    ch1 = b;
    done_seen = 0;
    ovr_seen = 0;
    conv_pulse();
    sck_bits(FW);
  endtask

  initial begin
    wait_clk(3);
    chk("reset_adc_out", 64'(adc_out), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    wait_clk(3);

`ifdef ADC_RESP_TEST_PATTERN_EN
    for (int f = 0; f < 3; f++) begin
      frame(14'h1ABC, 14'h0123);
      chk("pat_ch0", 64'(got[31:18]), 64'(f));
      chk("pat_ch1", 64'(got[15:2]), 64'(14'h3FFF - f));
    end
`else
    frame(14'h1ABC, 14'h0123);
    chk("frame1", 64'(got), 64'(34'b00_01101010111100_00_00000100100011_00));
    chk("frame1_done", 64'(done_seen), 64'd1);
    chk("frame1_ovr", 64'(ovr_seen), 64'd0);

    frame(14'h2000, 14'h1FFF);
    chk("neg_ch0", 64'(got[31:18]), 64'(14'b10000000000000));
    chk("pos_ch1", 64'(got[15:2]), 64'(14'b01111111111111));

    ch0 = 14'h1ABC;
    conv_pulse();
    sck_bits(10);
    done_seen = 0;
    ovr_seen = 0;
    ch0 = 14'h0005;
    conv_pulse();
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_ovr", 64'(ovr_seen), 64'd1);
    sck_bits(FW);
    chk("restart_frame", 64'(got), 64'({2'b00, 14'h0005, 2'b00, 14'h1FFF, 2'b00}));
    chk("restart_done", 64'(done_seen), 64'd1);
`endif

    done_seen = 0;
    ovr_seen = 0;
    sck_bits(20);
    chk("idle_sck_bits", 64'(got), 64'd0);
    chk("idle_sck_pulses", 64'(done_seen + ovr_seen), 64'd0);

    ch0 = 14'h2A5B;
    ch1 = 14'h15A4;
    conv_pulse();
    sck_bits(17);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_adc_out", 64'(adc_out), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
`ifndef ADC_RESP_TEST_PATTERN_EN
    frame(14'h2A5B, 14'h15A4);
    chk("post_rst_frame", 64'(got), 64'({2'b00, 14'h2A5B, 2'b00, 14'h15A4, 2'b00}));
    chk("post_rst_done", 64'(done_seen), 64'd1);

    ch0 = 14'h0F0F;
    ch1 = 14'h3003;
    conv_pulse();
    sck_bits(5);
    ovr_seen = 0;
    done_seen = 0;
    sck = 1'b1;
    wait_clk(10);
    sck = 1'b0;
    conv = 1'b1;
    wait_clk(4);
    conv = 1'b0;
    wait_clk(6);
    sck_bits(FW);
    chk("tie_frame", 64'(got), 64'({2'b00, 14'h0F0F, 2'b00, 14'h3003, 2'b00}));
    chk("tie_ovr", 64'(ovr_seen), 64'd1);
    chk("tie_done", 64'(done_seen), 64'd1);
`endif

    wait_clk(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
